// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: icache line reads, dcache line reads and dirty-line writebacks.
// Optional watchdog with sticky err is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int unsigned ARCH_BITS      = 32,
  parameter int unsigned LINE_BITS      = 128,
  parameter int unsigned OFFSET_BITS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rreq,
  input  logic [ARCH_BITS-1:0] i_raddr,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_rvalid,
  input  logic                 d_rreq,
  input  logic [ARCH_BITS-1:0] d_raddr,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_rvalid,
  input  logic                 d_wreq,
  input  logic [ARCH_BITS-1:0] d_waddr,
  input  logic [LINE_BITS-1:0] d_wline,
  output logic                 d_wack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ARCH_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wline,
  input  logic [LINE_BITS-1:0] mem_rline,
  input  logic                 mem_ready,
  output logic                 err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWb   = 2'd1;
  localparam logic [1:0] StRd   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [ARCH_BITS-1:0] AddrMask = {ARCH_BITS{1'b1}} << OFFSET_BITS;

  logic [1:0] state;
  logic       rrPtr;    // 1: icache received the last read grant
  logic       ownerD;   // read owner: 1 = dcache, 0 = icache
  logic       dropped;  // owner withdrew its request during the transaction
  logic       grantI;
  logic       grantD;
  logic       busy;
  logic       ownerReq;
  logic       stillWanted;
  logic       timeout;

  always_comb begin
    grantI      = i_rreq && (!d_rreq || !rrPtr);
    grantD      = d_rreq && (!i_rreq || rrPtr);
    busy        = (state == StWb) || (state == StRd);
    ownerReq    = (state == StWb) ? d_wreq : (ownerD ? d_rreq : i_rreq);
    stillWanted = ownerReq && !dropped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rrPtr     <= 1'b0;
      ownerD    <= 1'b0;
      dropped   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wline <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      d_wack    <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_wack   <= 1'b0;
      case (state)
        StIdle: begin
          // Eviction first so the dirty line reaches memory before its refill.
          if (d_wreq) begin
            state     <= StWb;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= d_waddr & AddrMask;
            mem_wline <= d_wline;
            dropped   <= 1'b0;
          end else if (grantI || grantD) begin
            state    <= StRd;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= (grantD ? d_raddr : i_raddr) & AddrMask;
            ownerD   <= grantD;
            dropped  <= 1'b0;
          end
        end
        StWb, StRd: begin
          if (mem_ready) begin
            state   <= StResp;
            mem_req <= 1'b0;
            if (state == StWb) begin
              d_wack <= stillWanted;
            end else if (ownerD) begin
              d_rdata  <= mem_rline;
              d_rvalid <= stillWanted;
              rrPtr    <= 1'b0;
            end else begin
              i_rdata  <= mem_rline;
              i_rvalid <= stillWanted;
              rrPtr    <= 1'b1;
            end
          end else if (timeout) begin
            state   <= StIdle;
            mem_req <= 1'b0;
          end else if (!ownerReq) begin
            dropped <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntBits = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntBits-1:0] toCnt;
  logic               errReg;

  assign timeout = busy && !mem_ready && (toCnt == CntBits'(TIMEOUT_CYCLES - 1));
  assign err     = errReg;

  // Counter idles at zero outside WB/RD, so every state entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt  <= '0;
      errReg <= 1'b0;
    end else begin
      toCnt <= (busy && !timeout) ? toCnt + 1'b1 : '0;
      if (timeout) begin
        errReg <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
